// File: rtl/ps2_event_receiver.sv
// ps2_event_receiver: filtered PS/2 receiver that decodes E0/F0-prefixed scan codes into
// make/break events held in a show-ahead FIFO; define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_event_receiver #(
    parameter int FILTER_LEN     = 20,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        kb_clk,
    input  logic                        kb_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_ext,
    output logic                        evt_brk,
    output logic [$clog2(FIFO_DEPTH):0] evt_count,
    output logic [31:0]                 raw_hist,
    output logic                        perr,
    output logic                        ferr,
    output logic                        ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_PAR = 2'd2, S_STOP = 2'd3;

    logic [1:0]         r_sync1, r_sync2, r_filt;  // bit 0: kb_clk, bit 1: kb_data
    logic [1:0][FW-1:0] r_fcnt;
    logic               r_clk_prev;
    logic [1:0]         r_state;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic [TW-1:0]      r_tmo;
    logic               r_done, r_ferr;
    logic               r_ext_pend, r_brk_pend;
    logic [9:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [AW:0]        r_count;
    logic               w_fall, w_dat, w_tmo, w_push_req, w_full, w_pop, w_push;
    logic [9:0]         w_head;
`ifdef PS2_PARITY_CHECK_EN
    logic               r_par, r_perr;
    assign perr = r_perr;
`else
    assign perr = 1'b0;
`endif

    // A filtered line only flips after FILTER_LEN consecutive samples disagree with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_filt     <= 2'b11;
            r_fcnt     <= '0;
            r_clk_prev <= 1'b1;
        end else begin
            r_sync1    <= {kb_data, kb_clk};
            r_sync2    <= r_sync1;
            r_clk_prev <= r_filt[0];
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_filt[k]) r_fcnt[k] <= '0;
                else if (r_fcnt[k] == FILT_MAX) begin
                    r_filt[k] <= r_sync2[k];
                    r_fcnt[k] <= '0;
                end else r_fcnt[k] <= r_fcnt[k] + FW'(1);
            end
        end
    end

    assign w_fall = r_clk_prev & ~r_filt[0];
    assign w_dat  = r_filt[1];
    assign w_tmo  = (r_state != S_IDLE) && (r_tmo == TMO_MAX);
    assign ferr   = r_ferr | w_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
            r_shift <= '0;
            r_tmo   <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_perr <= 1'b0;
`endif
            r_tmo  <= (r_state == S_IDLE || w_fall || w_tmo) ? '0 : r_tmo + TW'(1);
            if (w_tmo) r_state <= S_IDLE;
            else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        r_bit   <= '0;
                        r_state <= w_dat ? S_IDLE : S_DATA;
                    end
                    S_DATA: begin
                        r_shift <= {w_dat, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        r_state <= (r_bit == 3'd7) ? S_PAR : S_DATA;
                    end
                    S_PAR: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_par   <= w_dat;
`endif
                        r_state <= S_STOP;
                    end
                    default: begin
                        r_ferr  <= ~w_dat;
`ifdef PS2_PARITY_CHECK_EN
                        r_perr  <= w_dat & ~(^{r_shift, r_par});
                        r_done  <= w_dat & (^{r_shift, r_par});
`else
                        r_done  <= w_dat;
`endif
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_push_req = r_done && r_shift != 8'hE0 && r_shift != 8'hF0;
    assign w_full     = r_count == FULL;
    assign w_pop      = evt_valid & evt_ready;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign ovf        = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_hist   <= '0;
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (perr || ferr) {r_ext_pend, r_brk_pend} <= 2'b00;
            else if (r_done) begin
                raw_hist   <= {raw_hist[23:0], r_shift};
                r_ext_pend <= (r_shift == 8'hE0) | (r_ext_pend & r_shift == 8'hF0);
                r_brk_pend <= (r_shift == 8'hF0) | (r_brk_pend & r_shift == 8'hE0);
            end
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= (w_push && !w_pop) ? r_count + (AW+1)'(1) :
                       (!w_push && w_pop) ? r_count - (AW+1)'(1) : r_count;
        end
    end

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wptr] <= {r_brk_pend, r_ext_pend, r_shift};

    assign w_head                      = r_mem[r_rptr];
    assign evt_valid                   = r_count != '0;
    assign evt_count                   = r_count;
    assign {evt_brk, evt_ext, evt_code} = evt_valid ? w_head : '0;
endmodule

// File: doc/ps2_event_receiver.md
# ps2_event_receiver

Parametrised PS/2 keyboard receiver for the keyboard input path, sitting between the board's PS/2 pins and the consumer logic. It synchronises and filters the PS/2 clock and data lines, and frames 11-bit packets: start, 8 data bits LSB first, odd parity, stop. It decodes E0/F0 prefixes into make/break events and buffers those events in a show-ahead FIFO with a valid/ready handshake. All logic runs in the system clock domain; nothing is clocked by the PS/2 clock.

## Interface
- FILTER_LEN, 20: consecutive identical synchronised samples required before a filtered line changes (≥2).
- FIFO_DEPTH, 8: event FIFO depth (power of two, ≥2).
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge before an open frame is abandoned.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- kb_clk  in  1  PS/2 clock pin (asynchronous).
- kb_data  in  1  PS/2 data pin (asynchronous).
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head when high together with evt_valid.
- evt_code  out  8  head scan code.
- evt_ext  out  1  head was preceded by E0.
- evt_brk  out  1  head was preceded by F0 (key release).
- evt_count  out  $clog2(FIFO_DEPTH)+1  number of stored events.
- raw_hist  out  32  last four accepted raw bytes, including prefixes; newest in [7:0].
- perr  out  1  one-cycle pulse: parity error.
- ferr  out  1  one-cycle pulse: start/stop framing error or timeout.
- ovf  out  1  one-cycle pulse: event dropped because FIFO full.

## Operation
- Input path: 2-flop synchroniser per line, then a filter per line. The filtered output takes the new level after FILTER_LEN consecutive equal samples. Filtered outputs reset to 1.
- Edge detect: a filtered kb_clk 1→0 transition produces a one-cycle `fall` strobe.
- Frame FSM (on `fall` only): IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: data=0 → DATA, bit counter 0. Data=1 is ignored and stays IDLE (glitch/start reject).
  - DATA: shift data in LSB first; after 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: data=1 → frame accepted (`byte_done`); data=0 → ferr, byte discarded. Both → IDLE.
- Timeout: in any non-IDLE state, a cycle counter counts clk cycles since the last `fall`. At TIMEOUT_CYCLES the FSM goes to IDLE, pulses ferr and discards partial data. The counter clears on every `fall` and in IDLE.
- Decoder, on `byte_done`:
  - raw_hist shifts left 8 and takes the byte.
  - E0 sets ext_pend. F0 sets brk_pend. Neither is pushed.
  - Any other byte pushes {brk_pend, ext_pend, byte} and clears both pend flags.
  - E1 is pushed as a plain code.
  - A ferr or perr also clears both pend flags.
- FIFO: circular, show-ahead.
  - Push when full: the event is dropped, ovf pulses, and contents are unchanged.
  - Pop (evt_valid & evt_ready) when empty is impossible; evt_ready while empty is ignored.
  - Push and pop in the same cycle while full: both happen and count stays FIFO_DEPTH, no ovf.
  - Push and pop in the same cycle while non-empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (any time, including mid-frame):
  - FSM IDLE, counters 0, pend flags 0, FIFO empty.
  - evt_valid=0, evt_code=0, evt_ext=0, evt_brk=0, evt_count=0.
  - raw_hist=0, perr=ferr=ovf=0.
  - Filtered lines = 1.

## Timing
- Pin edge to `fall`: 2 (sync) + FILTER_LEN cycles, ±1.
- `byte_done`/perr/ferr are asserted in the cycle after the STOP-bit `fall` (cycle N).
- raw_hist and the pend flags update at the end of cycle N.
- FIFO write occurs at the end of cycle N. evt_valid is high in cycle N+1 if the FIFO was empty.
- ovf pulses in cycle N.
- Head fields are stable while evt_valid is high and no pop occurs. After a pop, the next head appears in the following cycle.
- A timeout ferr is asserted in the cycle the counter reaches TIMEOUT_CYCLES.

## Configuration
- PS2_PARITY_CHECK_EN defined:
  - Odd parity is checked at STOP.
  - On mismatch, perr pulses, the byte is discarded (no raw_hist or FIFO update) and the pend flags clear.
  - If stop is also bad, only ferr pulses.
- PS2_PARITY_CHECK_EN undefined: the parity bit is ignored and perr is tied 0.

## Test plan
- Reset, then one frame 0x1C with correct parity/stop, evt_ready=0 → evt_valid=1, evt_code=1C, ext=0, brk=0, evt_count=1, raw_hist=0000001C.
- Frames E0, F0, 75 → exactly one event: code=75, ext=1, brk=1. raw_hist=00E0F075.
- With PS2_PARITY_CHECK_EN, 0x1C with even parity → perr one cycle, evt_count=0, raw_hist unchanged.
- Without the macro, the same frame → event 1C.
- Send 5 bits of a frame, then idle for TIMEOUT_CYCLES → ferr one cycle, FSM IDLE. A following clean 0x2A → event 2A.
- evt_ready=0, send 9 codes 0x01..0x09 with FIFO_DEPTH=8 → ovf on the 9th, count=8. Then evt_ready=1 → pops 01..08 in order, evt_valid falls after 08.
- Assert rst mid-frame (after 4 data bits), release, send 0x1C → only event 1C. All outputs read their reset values during rst.
